// File: rtl/running_add_if.sv
// running_add_if: sample stream in, packed window sums out
interface running_add_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 16
);
    logic [DATA_WIDTH-1:0]       i_data;
    logic                        i_data_valid;
    logic [DATA_WIDTH*LANES-1:0] o_data;
    logic                        o_data_valid;

    modport master (output i_data, i_data_valid, input o_data, o_data_valid);
    modport slave  (input i_data, i_data_valid, output o_data, o_data_valid);
endinterface

// File: rtl/running_add.sv
// running_add: sliding-window accumulator giving all 16 trailing-window sums per sample
module running_add #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 16
) (
    input logic          clock,
    input logic          reset,
    running_add_if.slave bus
);
    logic [DATA_WIDTH-1:0]       hist [LANES];
    logic [DATA_WIDTH*LANES-1:0] sums;
    logic [DATA_WIDTH-1:0]       acc;

    // Prefix sums of the incoming sample followed by the pre-shift history, modulo 2^16 per lane
    always_comb begin
        acc  = bus.i_data;
        sums = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k > 0) acc = acc + hist[k-1];
            sums[k*DATA_WIDTH +: DATA_WIDTH] = acc;
        end
    end

    // Shift history and register the window sums on each accepted sample
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int j = 0; j < LANES; j++) hist[j] <= '0;
            bus.o_data       <= '0;
            bus.o_data_valid <= 1'b0;
        end else begin
            bus.o_data_valid <= bus.i_data_valid;
            if (bus.i_data_valid) begin
                hist[0] <= bus.i_data;
                for (int j = 1; j < LANES; j++) hist[j] <= hist[j-1];
                bus.o_data <= sums;
            end
        end
    end
endmodule

// File: tb/tb_running_add.sv
// tb_running_add: directed checks of window sums, latency, wrap-around and mid-stream reset
module tb_running_add;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   passed = 0;
    logic [255:0] exp_word;

    running_add_if bus ();

    running_add dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s got %h want %h", tag, obs, expv);
    endtask

    task automatic step(input logic v, input logic [15:0] d);
        bus.i_data_valid = v;
        bus.i_data = d;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b0, 16'h0);
        reset = 1'b1;
    endtask

    function automatic logic [255:0] rep(input logic [15:0] v);
        return {16{v}};
    endfunction

    initial begin
        bus.i_data = '0;
        bus.i_data_valid = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'($urandom));
            chk("rst_data", bus.o_data, '0);
            chk("rst_valid", {255'b0, bus.o_data_valid}, '0);
        end
        reset = 1'b1;
        step(1'b0, 16'h0);
        chk("release_valid", {255'b0, bus.o_data_valid}, '0);
        chk("release_data", bus.o_data, '0);

        step(1'b1, 16'h0001);
        chk("single_valid", {255'b0, bus.o_data_valid}, 256'd1);
        chk("single_data", bus.o_data, rep(16'h0001));
        step(1'b0, 16'h1234);
        chk("single_after_valid", {255'b0, bus.o_data_valid}, '0);
        chk("single_hold", bus.o_data, rep(16'h0001));

        do_reset();
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 16'(i));
            chk("ramp_valid", {255'b0, bus.o_data_valid}, 256'd1);
        end
        exp_word = {{6{16'd55}}, 16'd55, 16'd54, 16'd52, 16'd49, 16'd45,
                    16'd40, 16'd34, 16'd27, 16'd19, 16'd10};
        chk("ramp_data", bus.o_data, exp_word);
        step(1'b0, 16'h0);
        chk("ramp_end_valid", {255'b0, bus.o_data_valid}, '0);

        do_reset();
        for (int i = 0; i < 17; i++) step(1'b1, 16'h0001);
        for (int k = 0; k < 16; k++) exp_word[k*16 +: 16] = 16'(k + 1);
        chk("slide_data", bus.o_data, exp_word);
        chk("slide_valid", {255'b0, bus.o_data_valid}, 256'd1);

        do_reset();
        step(1'b1, 16'hFFFF);
        chk("wrap_first", bus.o_data, rep(16'hFFFF));
        step(1'b1, 16'h0002);
        chk("wrap_second", bus.o_data, {rep(16'h0001)} & ~256'hFFFF | 256'h0002);

        do_reset();
        step(1'b1, 16'd5);
        chk("gap_v5", {255'b0, bus.o_data_valid}, 256'd1);
        chk("gap_d5", bus.o_data, rep(16'd5));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'd99);
            chk("gap_idle_valid", {255'b0, bus.o_data_valid}, '0);
        end
        chk("gap_idle_hold", bus.o_data, rep(16'd5));
        step(1'b1, 16'd7);
        chk("gap_v7", {255'b0, bus.o_data_valid}, 256'd1);
        chk("gap_d7", bus.o_data, {{15{16'd12}}, 16'd7});
        reset = 1'b0;
        step(1'b1, 16'd9);
        chk("midrst_valid", {255'b0, bus.o_data_valid}, '0);
        chk("midrst_data", bus.o_data, '0);
        reset = 1'b1;
        step(1'b1, 16'd3);
        chk("after_rst_valid", {255'b0, bus.o_data_valid}, 256'd1);
        chk("after_rst_data", bus.o_data, rep(16'd3));
        step(1'b0, 16'd0);
        chk("after_rst_end", {255'b0, bus.o_data_valid}, '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/running_add.md
# running_add

Sliding-window accumulator on a 16-bit sample stream. Every valid input sample is shifted into a 16-deep history. One cycle later the block presents a 256-bit word of 16 packed partial sums: lane k holds the sum of the most recent k+1 samples. It sits after the sample source in the equalizer datapath and feeds downstream filter/decision logic that selects the window length it needs.

## Interface
- DATA_WIDTH, 16, width of each input sample and of each output lane
- LANES, 16, history depth and number of output lanes; output width = DATA_WIDTH*LANES
- clock  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clock
- i_data  input  16  input sample, unsigned
- i_data_valid  input  1  i_data is consumed on a rising edge where this is 1
- o_data  output  256  packed window sums; lane k occupies bits [16k+15:16k]
- o_data_valid  output  1  o_data is a new result this cycle

## Operation
- History registers h[0..15], 16 bits each. h[0] is the newest sample.
- On a rising edge with reset low:
  - h[*], o_data and o_data_valid are cleared to 0.
  - i_data_valid is ignored.
- On a rising edge with reset high and i_data_valid=1:
  - History shifts: h[j] <= h[j-1] for j=1..15, and h[0] <= i_data. The oldest sample is discarded.
  - o_data lane k <= i_data + h[0] + ... + h[k-1], using the pre-shift history. This equals the sum of the new history entries 0..k.
  - o_data_valid <= 1.
- On a rising edge with reset high and i_data_valid=0:
  - History holds.
  - o_data holds its last value.
  - o_data_valid <= 0.
- Arithmetic:
  - Unsigned, modulo 2^16 per lane. Carries out of bit 15 are discarded and no saturation is applied.
  - Lanes are independent; no carry crosses a lane boundary.
- Lanes whose window reaches beyond the number of samples received since reset sum the zero-initialised entries. Until 16 samples have arrived, lanes k >= n-1 all equal the total of the n samples received.
- There is no backpressure; the block accepts one sample every cycle indefinitely.
- Implementation structure is free (adder chain, prefix tree, pipelined internal stages), provided the observable latency below holds.

## Timing
- Reset values: o_data = 0, o_data_valid = 0, all history = 0.
- Latency is exactly 1 cycle: a sample accepted at edge N produces o_data_valid=1 and the corresponding o_data after edge N, stable until edge N+1.
- Back-to-back valids give back-to-back o_data_valid pulses, one result per accepted sample. The number of o_data_valid cycles always equals the number of accepted samples.
- o_data_valid is a registered copy of (i_data_valid AND reset high).
- Reset asserted mid-stream:
  - Takes effect at the next edge.
  - An input valid on that same edge is dropped.
  - No o_data_valid is produced for it.
  - The next accepted sample starts from an empty (all-zero) history.
- The outputs depend only on registered state; there is no combinational path from inputs to outputs.

## Test plan
- Reset check: hold reset low for 10 cycles with random i_data and i_data_valid=1, then release. Required: o_data = 0 and o_data_valid = 0 throughout, and no valid pulse on the first cycle after release.
- Single sample: after reset, apply 0x0001 with valid for one cycle. Required: one cycle later o_data_valid=1 for exactly one cycle, and all 16 lanes = 0x0001. Afterwards o_data holds with valid=0.
- Ramp of 10 samples: apply 1..10 on consecutive cycles. Required:
  - Exactly 10 consecutive o_data_valid pulses.
  - After the 10th sample: lane0 = 10, lane1 = 19, lane2 = 27, …, lane9 = 55, lanes 10..15 = 55.
- Window slide: apply 17 samples of 0x0001. Required: the final result has lane k = k+1 for k=0..15, with lane15 = 16, not 17.
- Wrap-around: apply 0xFFFF then 0x0002. Required: the second result has lane0 = 0x0002, lanes 1..15 = 0x0001, and no carry into adjacent lanes.
- Gapped input and mid-stream reset:
  - Apply 5, idle 3 cycles, then 7. Required: valid pulses only after 5 and after 7; the second result has lane0 = 7 and lane1 = 12.
  - Then pulse reset low for one cycle with valid=1 and apply 3. Required: the dropped sample produces no output; the result for 3 has all lanes = 3.
